// File: rtl/pipe_ctrl.sv
// Pipeline controller for the IF/ID, ID/EX, EX/MEM, MEM/WB registers. It drives stall/flush
// and PC redirects and holds the exception state, draining the bus before an exception redirect.
module pipe_ctrl #(
    parameter int unsigned WORD_ADDR_W  = 30,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned EXP_W        = 3,
    parameter int unsigned CTRL_OP_W    = 2,
    parameter logic [CTRL_OP_W-1:0]   CTRL_OP_ERET = 2'd2,
    parameter logic [WORD_ADDR_W-1:0] EXC_VECTOR   = 30'h0000_0040,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [REG_ADDR_W-1:0]  IDRdAddr0,
    input  logic [REG_ADDR_W-1:0]  IDRdAddr1,
    input  logic                   IDUsesRd0,
    input  logic                   IDUsesRd1,
    input  logic                   EXIsLoad,
    input  logic [REG_ADDR_W-1:0]  EXDstAddr,
    input  logic                   EXGPRWE_,
    input  logic                   BrTaken,
    input  logic [WORD_ADDR_W-1:0] BrTarget,
    input  logic                   MemBusy,
    input  logic                   MEMEn,
    input  logic [WORD_ADDR_W-1:0] MEMPC,
    input  logic [EXP_W-1:0]       MEMExpCode,
    input  logic [CTRL_OP_W-1:0]   MEMCtrlOp,
    output logic                   IFStall,
    output logic                   IDStall,
    output logic                   EXStall,
    output logic                   MEMStall,
    output logic                   IFFlush,
    output logic                   IDFlush,
    output logic                   EXFlush,
    output logic                   MEMFlush,
    output logic                   PCLoad,
    output logic [WORD_ADDR_W-1:0] NewPC,
    output logic [WORD_ADDR_W-1:0] EPC,
    output logic [EXP_W-1:0]       ExpCause,
    output logic                   ExpMode,
    output logic                   Halted,
    output logic [CNT_W-1:0]       StallCnt
);

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [WORD_ADDR_W-1:0] r_epc;
    logic [EXP_W-1:0]       r_cause;
    logic                   r_exp_mode;
    logic                   r_halted;
    logic [CNT_W-1:0]       r_stall_cnt;

    logic w_exc;
    logic w_eret;
    logic w_load_use;
    logic w_capture;
    logic w_set_mode;
    logic w_clr_mode;
    logic w_set_halt;

    assign w_exc  = MEMEn && (MEMExpCode != '0);
    assign w_eret = MEMEn && (MEMCtrlOp == CTRL_OP_ERET) && !w_exc;
    assign w_load_use = EXIsLoad && !EXGPRWE_ && (EXDstAddr != '0) &&
                        ((IDUsesRd0 && (IDRdAddr0 == EXDstAddr)) ||
                         (IDUsesRd1 && (IDRdAddr1 == EXDstAddr)));

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_set_mode  = 1'b0;
        w_clr_mode  = 1'b0;
        w_set_halt  = 1'b0;
        IFStall     = 1'b0;
        IDStall     = 1'b0;
        EXStall     = 1'b0;
        MEMStall    = 1'b0;
        IFFlush     = 1'b0;
        IDFlush     = 1'b0;
        EXFlush     = 1'b0;
        MEMFlush    = 1'b0;
        PCLoad      = 1'b0;
        NewPC       = '0;
        // Outputs are forced quiet while reset is asserted.
        if (!reset_) begin
            unique case (r_state)
                StRun: begin
                    if (w_exc && r_exp_mode) begin
                        w_state_nxt = StHalt;
                        w_set_halt  = 1'b1;
                        {IFStall, IDStall, EXStall, MEMStall} = 4'hf;
                    end else if (w_exc && MemBusy) begin
                        w_state_nxt = StDrain;
                        w_capture   = 1'b1;
                        {IFStall, IDStall, EXStall, MEMStall} = 4'hf;
                    end else if (w_exc) begin
                        w_capture  = 1'b1;
                        w_set_mode = 1'b1;
                        {IFFlush, IDFlush, EXFlush, MEMFlush} = 4'hf;
                        PCLoad = 1'b1;
                        NewPC  = EXC_VECTOR;
                    end else if (w_eret) begin
                        w_clr_mode = 1'b1;
                        {IFFlush, IDFlush, EXFlush, MEMFlush} = 4'hf;
                        PCLoad = 1'b1;
                        NewPC  = r_epc;
                    end else if (MemBusy) begin
                        {IFStall, IDStall, EXStall, MEMStall} = 4'hf;
                    end else if (w_load_use) begin
                        IFStall = 1'b1;
                        IDFlush = 1'b1;
                    end else if (BrTaken) begin
                        IFFlush = 1'b1;
                        PCLoad  = 1'b1;
                        NewPC   = BrTarget;
                    end
                end
                StDrain: begin
                    if (MemBusy) begin
                        {IFStall, IDStall, EXStall, MEMStall} = 4'hf;
                    end else begin
                        w_state_nxt = StRun;
                        w_set_mode  = 1'b1;
                        {IFFlush, IDFlush, EXFlush, MEMFlush} = 4'hf;
                        PCLoad = 1'b1;
                        NewPC  = EXC_VECTOR;
                    end
                end
                StHalt: begin
                    {IFStall, IDStall, EXStall, MEMStall} = 4'hf;
                end
                default: w_state_nxt = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            r_state     <= StRun;
            r_epc       <= '0;
            r_cause     <= '0;
            r_exp_mode  <= 1'b0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_epc   <= MEMPC;
                r_cause <= MEMExpCode;
            end
            if (w_set_mode) begin
                r_exp_mode <= 1'b1;
            end else if (w_clr_mode) begin
                r_exp_mode <= 1'b0;
            end
            if (w_set_halt) begin
                r_halted <= 1'b1;
            end
            if (IFStall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign EPC      = r_epc;
    assign ExpCause = r_cause;
    assign ExpMode  = r_exp_mode;
    assign Halted   = r_halted;
    assign StallCnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model of the controller.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    logic        clk;
    logic        reset_;
    logic [4:0]  IDRdAddr0, IDRdAddr1, EXDstAddr;
    logic        IDUsesRd0, IDUsesRd1, EXIsLoad, EXGPRWE_, BrTaken, MemBusy, MEMEn;
    logic [29:0] BrTarget, MEMPC;
    logic [2:0]  MEMExpCode;
    logic [1:0]  MEMCtrlOp;
    logic        IFStall, IDStall, EXStall, MEMStall;
    logic        IFFlush, IDFlush, EXFlush, MEMFlush;
    logic        PCLoad, ExpMode, Halted;
    logic [29:0] NewPC, EPC;
    logic [2:0]  ExpCause;
    logic [CNT_W-1:0] StallCnt;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_(reset_),
        .IDRdAddr0(IDRdAddr0), .IDRdAddr1(IDRdAddr1),
        .IDUsesRd0(IDUsesRd0), .IDUsesRd1(IDUsesRd1),
        .EXIsLoad(EXIsLoad), .EXDstAddr(EXDstAddr), .EXGPRWE_(EXGPRWE_),
        .BrTaken(BrTaken), .BrTarget(BrTarget), .MemBusy(MemBusy),
        .MEMEn(MEMEn), .MEMPC(MEMPC), .MEMExpCode(MEMExpCode), .MEMCtrlOp(MEMCtrlOp),
        .IFStall(IFStall), .IDStall(IDStall), .EXStall(EXStall), .MEMStall(MEMStall),
        .IFFlush(IFFlush), .IDFlush(IDFlush), .EXFlush(EXFlush), .MEMFlush(MEMFlush),
        .PCLoad(PCLoad), .NewPC(NewPC), .EPC(EPC), .ExpCause(ExpCause),
        .ExpMode(ExpMode), .Halted(Halted), .StallCnt(StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Behavioural model: mode 0 = running, 1 = waiting for bus, 2 = halted.
    int          m_mode;
    logic [29:0] m_epc;
    logic [2:0]  m_cause;
    bit          m_exp, m_halt;
    int          m_cnt;

    always @(negedge clk) begin
        bit exc, eret, lu, redirect;
        bit [3:0] stall, flush;
        logic [29:0] tgt;
        bit pcl;
        stall = 0; flush = 0; pcl = 0; tgt = 0; redirect = 0;
        exc  = MEMEn && MEMExpCode != 0;
        eret = MEMEn && MEMCtrlOp == 2 && !exc;
        lu   = EXIsLoad && !EXGPRWE_ && EXDstAddr != 0 &&
               ((IDUsesRd0 && IDRdAddr0 == EXDstAddr) || (IDUsesRd1 && IDRdAddr1 == EXDstAddr));
        if (reset_) begin
            m_mode = 0; m_epc = 0; m_cause = 0; m_exp = 0; m_halt = 0; m_cnt = 0;
        end else if (m_mode == 2) begin
            stall = 4'hf;
        end else if (m_mode == 1) begin
            if (MemBusy) stall = 4'hf;
            else begin redirect = 1; tgt = 30'h40; end
        end else if (exc && m_exp) begin
            stall = 4'hf;
        end else if (exc && MemBusy) begin
            stall = 4'hf;
        end else if (exc) begin
            redirect = 1; tgt = 30'h40;
        end else if (eret) begin
            redirect = 1; tgt = m_epc;
        end else if (MemBusy) begin
            stall = 4'hf;
        end else if (lu) begin
            stall = 4'b1000; flush = 4'b0100;
        end else if (BrTaken) begin
            flush = 4'b1000; pcl = 1; tgt = BrTarget;
        end
        if (redirect) begin flush = 4'hf; pcl = 1; end

        chk("stalls", {IFStall, IDStall, EXStall, MEMStall}, stall);
        chk("flushes", {IFFlush, IDFlush, EXFlush, MEMFlush}, flush);
        chk("PCLoad", PCLoad, pcl);
        chk("NewPC", NewPC, tgt);
        chk("EPC", EPC, m_epc);
        chk("ExpCause", ExpCause, m_cause);
        chk("ExpMode", ExpMode, m_exp);
        chk("Halted", Halted, m_halt);
        chk("StallCnt", StallCnt, m_cnt);

        // Advance to the state after the coming rising edge.
        if (!reset_) begin
            if (stall[3] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (m_mode == 1) begin
                if (!MemBusy) begin m_mode = 0; m_exp = 1; end
            end else if (m_mode == 0 && exc) begin
                if (m_exp) begin m_mode = 2; m_halt = 1; end
                else begin
                    m_epc = MEMPC; m_cause = MEMExpCode;
                    if (MemBusy) m_mode = 1; else m_exp = 1;
                end
            end else if (m_mode == 0 && eret) begin
                m_exp = 0;
            end
        end
    end

    task automatic idle();
        IDRdAddr0 = 0; IDRdAddr1 = 0; IDUsesRd0 = 0; IDUsesRd1 = 0;
        EXIsLoad = 0; EXDstAddr = 0; EXGPRWE_ = 1; BrTaken = 0; BrTarget = 0;
        MemBusy = 0; MEMEn = 0; MEMPC = 0; MEMExpCode = 0; MEMCtrlOp = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exc(input logic busy);
        MEMEn = 1; MEMExpCode = 3; MEMPC = 30'h2A; MemBusy = busy;
    endtask

    initial begin
        idle();
        reset_ = 1;
        step();
        step();
        @(negedge clk);
        chk("rst IFStall", IFStall, 0);
        chk("rst PCLoad", PCLoad, 0);
        chk("rst ExpMode", ExpMode, 0);
        step();
        reset_ = 0;

        // Load-use on source 1
        EXIsLoad = 1; EXGPRWE_ = 0; EXDstAddr = 5; IDUsesRd1 = 1; IDRdAddr1 = 5;
        @(negedge clk);
        chk("lu IFStall", IFStall, 1);
        chk("lu IDFlush", IDFlush, 1);
        chk("lu PCLoad", PCLoad, 0);
        chk("lu cnt before", StallCnt, 0);
        step();
        EXDstAddr = 0; IDRdAddr1 = 0;
        @(negedge clk);
        chk("lu cnt after", StallCnt, 1);
        chk("lu r0 IFStall", IFStall, 0);
        step();

        // Branch alone, then with a coincident load-use
        idle();
        BrTaken = 1; BrTarget = 30'h100;
        @(negedge clk);
        chk("br IFFlush", IFFlush, 1);
        chk("br PCLoad", PCLoad, 1);
        chk("br NewPC", NewPC, 30'h100);
        step();
        EXIsLoad = 1; EXGPRWE_ = 0; EXDstAddr = 5; IDUsesRd1 = 1; IDRdAddr1 = 5;
        @(negedge clk);
        chk("br+lu PCLoad", PCLoad, 0);
        chk("br+lu IFFlush", IFFlush, 0);
        chk("br+lu IDFlush", IDFlush, 1);
        step();

        // Exception without bus activity
        idle();
        set_exc(0);
        @(negedge clk);
        chk("exc MEMFlush", MEMFlush, 1);
        chk("exc NewPC", NewPC, 30'h40);
        step();
        idle();
        @(negedge clk);
        chk("exc EPC", EPC, 30'h2A);
        chk("exc cause", ExpCause, 3);
        chk("exc mode", ExpMode, 1);

        // ERET
        MEMEn = 1; MEMCtrlOp = 2;
        @(negedge clk);
        chk("eret NewPC", NewPC, 30'h2A);
        chk("eret IFFlush", IFFlush, 1);
        step();
        idle();
        @(negedge clk);
        chk("eret mode", ExpMode, 0);

        // Exception while the bus is busy for three cycles
        set_exc(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drain MEMStall", MEMStall, 1);
            chk("drain PCLoad", PCLoad, 0);
            step();
        end
        MemBusy = 0;
        @(negedge clk);
        chk("drain NewPC", NewPC, 30'h40);
        chk("drain PCLoad end", PCLoad, 1);
        step();
        idle();
        @(negedge clk);
        chk("drain mode", ExpMode, 1);
        chk("drain EPC", EPC, 30'h2A);
        chk("drain run", PCLoad, 0);

        // Nested exception halts until reset
        set_exc(0);
        step();
        idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt Halted", Halted, 1);
            chk("halt IFStall", IFStall, 1);
            step();
        end
        reset_ = 1;
        #1;
        chk("async Halted", Halted, 0);
        chk("async IFStall", IFStall, 0);
        chk("async EPC", EPC, 0);
        step();
        reset_ = 0;

        // Random phase
        for (int c = 0; c < 3000; c++) begin
            reset_    = ($urandom_range(0, 59) == 0);
            IDRdAddr0 = 5'($urandom_range(0, 3));
            IDRdAddr1 = 5'($urandom_range(0, 3));
            IDUsesRd0 = 1'($urandom);
            IDUsesRd1 = 1'($urandom);
            EXIsLoad  = 1'($urandom);
            EXDstAddr = 5'($urandom_range(0, 3));
            EXGPRWE_  = ($urandom_range(0, 3) == 0);
            BrTaken   = ($urandom_range(0, 2) == 0);
            BrTarget  = 30'($urandom);
            MemBusy   = ($urandom_range(0, 3) == 0);
            MEMEn     = 1'($urandom);
            MEMPC     = 30'($urandom);
            MEMExpCode = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            MEMCtrlOp = 2'($urandom);
            step();
        end
        idle();
        reset_ = 0;
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
